pin_bus_responder: RTL and testbench
====================================

# pin_bus_responder

Register-file responder behind the chip's pin interface: an external host (bench or bring-up MCU) runs a 4-phase strobe/ack handshake on the dedicated inputs and moves bytes over the bidirectional `uio` bus. The block synchronizes the host strobe, decodes read/write, accesses a small internal register file, and drives the acknowledge and status pins. It sits inside `tt_um_top` and owns `uo_out`, `uio_out` and `uio_oe`.

## Interface
- `NUM_REGS`, 16: implemented registers, 1..16; addresses at or above it are unmapped.
- `SYNC_STAGES`, 2: flops in the strobe synchronizer, at least 2.
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `ena`  in  1  design selected; low forces IDLE.
- `ui_in`  in  8  [0] strobe (asynchronous), [1] rw (1=read), [5:2] addr, [7:6] unused.
- `uio_in`  in  8  write data from the host.
- `uo_out`  out  8  [0] ack, [1] busy (state not IDLE), [2] err (sticky), [3] reserved 0, [7:4] transaction count.
- `uio_out`  out  8  read data.
- `uio_oe`  out  8  0xFF while returning read data, else 0x00.

## Operation
- States: IDLE, EXEC, ACK.
- IDLE: the synchronized strobe is seen high -> EXEC.
  - At that edge, latch rw, addr and `uio_in` from the pins.
  - The host must hold them stable from strobe rise until ack.
- EXEC, one cycle:
  - Write to a mapped address: update the register.
  - Read from a mapped address: load the register into `uio_out`.
  - Unmapped write: discarded. Unmapped read: returns 0x00. Either sets err.
  - Then -> ACK, increment the count (mod 16, 15 wraps to 0).
- ACK: ack=1, busy=1. For reads, `uio_oe`=0xFF and `uio_out` holds the data.
  - Synchronized strobe seen low -> IDLE. At that edge ack=0 and `uio_oe`=0x00.
  - `uio_out` keeps its last value.
- The next transaction needs the strobe seen low in IDLE first (edge detect). A strobe held high gives exactly one transaction.
- Strobe drops during EXEC: the access still completes, then ACK -> IDLE on the next low sample.
- `ena` low in any state: -> IDLE next edge, ack=0, `uio_oe`=0x00, no access. An EXEC in flight is aborted with no write and no count.
- Registers, err and count keep their values across `ena` toggles. Only `rst` clears them.
- `rst` mid-transaction overrides everything. The host sees ack drop and must restart.
- Reset values:
  - state IDLE.
  - `uo_out`=0x00, `uio_out`=0x00, `uio_oe`=0x00.
  - All registers 0x00, err=0, count=0.
  - Synchronizer flops 0.

## Timing
- All outputs are registered; no combinational path from pins to outputs.
- Strobe first sampled high at edge N:
  - Synchronizer output high after edge N+SYNC_STAGES-1.
  - IDLE->EXEC at edge N+SYNC_STAGES.
  - ack=1 after edge N+SYNC_STAGES+1 (with the default, 3 cycles after the first high sample).
- Strobe first sampled low at edge M in ACK: ack=0 and `uio_oe`=0x00 after edge M+SYNC_STAGES.
- Minimum full transaction: 2*SYNC_STAGES+2 cycles.
- Read data is valid on `uio_out` in the same cycle ack rises and stays stable until ack falls.

## Structure
- Package `pin_bus_pkg`:
  - state enum `pb_state_t`.
  - pin-index constants: `STB_BIT`=0, `RW_BIT`=1, `ADDR_LSB`=2, `ADDR_MSB`=5, `ACK_BIT`=0, `BUSY_BIT`=1, `ERR_BIT`=2, `CNT_LSB`=4.
- One sub-module, `pin_sync`: SYNC_STAGES-deep, parameterized-width flop chain, reset to 0, used for the strobe.
- The register file is a flop array inside `pin_bus_responder`.

## Test plan
- Reset: `rst`=1 for 2 cycles -> `uo_out`=0x00, `uio_oe`=0x00. A read of addr 3 after reset returns 0x00.
- Write addr 5 = 0xA7, then read addr 5:
  - Read returns 0xA7 with `uio_oe`=0xFF only during ack.
  - ack rises 3 cycles after strobe sampled high.
  - Count=2 after both transactions.
- NUM_REGS=8, write 0x55 to addr 12 then read addr 12 -> read returns 0x00, err=1. err stays 1 after a later valid access until `rst`.
- 17 back-to-back writes -> count wraps from 15 to 0 to 1. Strobe held high through ACK -> exactly one transaction counted.
- Drop `ena` in EXEC during a write of 0xFF to addr 2 -> ack never rises, addr 2 still reads its old value, count unchanged.
- Assert `rst` while ACK is high on a read -> the next cycle shows ack=0, `uio_oe`=0x00, count=0.

Source files
------------

// File: rtl/pin_bus_pkg.sv
// pin_bus_pkg: shared state encoding and pin bit positions for the pin bus responder.
package pin_bus_pkg;
    typedef enum logic [1:0] {IDLE, EXEC, ACK} pb_state_t;
    localparam int STB_BIT  = 0;
    localparam int RW_BIT   = 1;
    localparam int ADDR_LSB = 2;
    localparam int ADDR_MSB = 5;
    localparam int ACK_BIT  = 0;
    localparam int BUSY_BIT = 1;
    localparam int ERR_BIT  = 2;
    localparam int CNT_LSB  = 4;
endpackage

// File: rtl/pin_bus_responder_sync.sv
// pin_sync: STAGES-deep flop chain bringing asynchronous pins into the clk domain.
module pin_sync #(
    parameter int W      = 1,
    parameter int STAGES = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    logic [STAGES*W-1:0] sync_q, sync_d;
    always_comb sync_d = {sync_q[(STAGES-1)*W-1:0], d};
    always_ff @(posedge clk) sync_q <= rst ? '0 : sync_d;
    assign q = sync_q[STAGES*W-1 -: W];
endmodule

// File: rtl/pin_bus_responder.sv
// pin_bus_responder: 4-phase strobe/ack register-file responder on the pin interface.
module pin_bus_responder
    import pin_bus_pkg::*;
#(
    parameter int NUM_REGS    = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);
    logic stb_s;
    pin_sync #(.W(1), .STAGES(SYNC_STAGES)) u_sync (
        .clk(clk),
        .rst(rst),
        .d(ui_in[STB_BIT]),
        .q(stb_s)
    );
    pb_state_t state_q, state_d;
    logic armed_q, armed_d, rw_q, rw_d, err_q, err_d;
    logic [3:0] addr_q, addr_d, cnt_q, cnt_d;
    logic [7:0] wdata_q, wdata_d, rdata_q, rdata_d;
    // Sized to the full address space; slots at or above NUM_REGS are never written and stay 0.
    logic [7:0] regs_q [16];
    logic [7:0] regs_d [16];
    logic mapped;
    logic unused_pins;
    assign mapped      = int'(addr_q) < NUM_REGS;
    assign unused_pins = ^ui_in[7:6];
    always_comb begin
        state_d = state_q;
        armed_d = armed_q | ~stb_s;
        rw_d    = rw_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        regs_d  = regs_q;
        if (!ena) state_d = IDLE;
        else case (state_q)
            IDLE: if (stb_s && armed_q) begin
                state_d = EXEC;
                armed_d = 1'b0;
                rw_d    = ui_in[RW_BIT];
                addr_d  = ui_in[ADDR_MSB:ADDR_LSB];
                wdata_d = uio_in;
            end
            EXEC: begin
                state_d = ACK;
                cnt_d   = cnt_q + 4'd1;
                err_d   = err_q | ~mapped;
                if (rw_q) rdata_d = mapped ? regs_q[addr_q] : 8'h00;
                else if (mapped) regs_d[addr_q] = wdata_q;
            end
            ACK:     state_d = stb_s ? ACK : IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            armed_q <= 1'b1;
            rw_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
            regs_q  <= '{default: '0};
        end else begin
            state_q <= state_d;
            armed_q <= armed_d;
            rw_q    <= rw_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            regs_q  <= regs_d;
        end
    end
    assign uo_out  = {cnt_q, 1'b0, err_q, state_q != IDLE, state_q == ACK};
    assign uio_out = rdata_q;
    assign uio_oe  = {8{state_q == ACK && rw_q}};
endmodule

// File: tb/tb_pin_bus_responder.sv
// tb_pin_bus_responder: directed handshake sequences checked against a register/count model and read-data queue.
module tb_pin_bus_responder;
    logic clk = 1'b0, rst = 1'b1, ena = 1'b1;
    logic [7:0] ui_in = 8'h00, uio_in = 8'h00;
    logic [7:0] uo_out, uio_out, uio_oe;
    pin_bus_responder #(.NUM_REGS(8), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .ena(ena), .ui_in(ui_in), .uio_in(uio_in),
        .uo_out(uo_out), .uio_out(uio_out), .uio_oe(uio_oe)
    );
    always #5 clk = ~clk;
    int total = 0, bad = 0, cnt_m = 0;
    logic err_m = 1'b0, cur_rw = 1'b0;
    logic [7:0] mdl [16];
    logic [7:0] exp_q [$];
    task automatic step(int n = 1);
        repeat (n) begin @(posedge clk); #1; end
    endtask
    task automatic chk(string tag, logic [7:0] obs, logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
        end
    endtask
    task automatic reset_model();
        for (int i = 0; i < 16; i++) mdl[i] = 8'h00;
        cnt_m = 0;
        err_m = 1'b0;
    endtask
    task automatic launch(logic rw, logic [3:0] a, logic [7:0] d);
        cur_rw = rw;
        ui_in  = {2'b00, a, rw, 1'b1};
        uio_in = d;
        if (rw) exp_q.push_back(int'(a) < 8 ? mdl[a] : 8'h00);
        else if (int'(a) < 8) mdl[a] = d;
        if (int'(a) >= 8) err_m = 1'b1;
        cnt_m = (cnt_m + 1) % 16;
    endtask
    task automatic wait_ack(output int lat);
        lat = 0;
        while (!uo_out[0] && lat < 20) begin step(); lat++; end
        chk("ack_rise", {7'b0, uo_out[0]}, 8'h01);
        if (uo_out[0]) begin
            chk("busy_in_ack", {7'b0, uo_out[1]}, 8'h01);
            chk("err", {7'b0, uo_out[2]}, {7'b0, err_m});
            chk("count", {4'h0, uo_out[7:4]}, 8'(cnt_m));
            if (cur_rw) begin
                chk("rd_oe", uio_oe, 8'hFF);
                chk("sb_depth", 8'(exp_q.size()), 8'h01);
                if (exp_q.size() > 0) chk("rd_data", uio_out, exp_q.pop_front());
            end else chk("wr_oe", uio_oe, 8'h00);
        end
    endtask
    task automatic release_stb(output int lat);
        ui_in[0] = 1'b0;
        lat = 0;
        while (uo_out[0] && lat < 20) begin step(); lat++; end
        chk("ack_fall", {7'b0, uo_out[0]}, 8'h00);
        chk("oe_fall", uio_oe, 8'h00);
        chk("idle_busy", {7'b0, uo_out[1]}, 8'h00);
    endtask
    task automatic txn(logic rw, logic [3:0] a, logic [7:0] d);
        int l;
        launch(rw, a, d);
        wait_ack(l);
        release_stb(l);
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
    initial begin
        int lat;
        reset_model();
        step(2);
        chk("rst_uo", uo_out, 8'h00);
        chk("rst_oe", uio_oe, 8'h00);
        chk("rst_uio_out", uio_out, 8'h00);
        rst = 1'b0;
        step();
        txn(1'b1, 4'd3, 8'h00);
        launch(1'b0, 4'd5, 8'hA7);
        wait_ack(lat);
        chk("ack_latency", 8'(lat), 8'd4);
        release_stb(lat);
        chk("ack_fall_latency", 8'(lat), 8'd3);
        txn(1'b1, 4'd5, 8'h00);
        chk("uio_out_keep", uio_out, 8'hA7);
        txn(1'b0, 4'd12, 8'h55);
        txn(1'b1, 4'd12, 8'h00);
        chk("err_set", {7'b0, uo_out[2]}, 8'h01);
        txn(1'b0, 4'd1, 8'h3C);
        txn(1'b1, 4'd1, 8'h00);
        chk("err_sticky", {7'b0, uo_out[2]}, 8'h01);
        launch(1'b0, 4'd4, 8'h9E);
        wait_ack(lat);
        step(10);
        chk("held_ack", {7'b0, uo_out[0]}, 8'h01);
        chk("held_count", {4'h0, uo_out[7:4]}, 8'(cnt_m));
        release_stb(lat);
        step(6);
        chk("held_once", {4'h0, uo_out[7:4]}, 8'(cnt_m));
        txn(1'b0, 4'd2, 8'h11);
        ui_in  = {2'b00, 4'd2, 1'b0, 1'b1};
        uio_in = 8'hFF;
        step(3);
        chk("exec_state", uo_out[1:0], 8'h02);
        ena = 1'b0;
        step();
        chk("ena_abort", uo_out[1:0], 8'h00);
        chk("ena_abort_oe", uio_oe, 8'h00);
        ena = 1'b1;
        step(6);
        chk("no_retrigger", uo_out[1:0], 8'h00);
        ui_in[0] = 1'b0;
        step(4);
        chk("abort_count", {4'h0, uo_out[7:4]}, 8'(cnt_m));
        txn(1'b1, 4'd2, 8'h00);
        launch(1'b1, 4'd5, 8'h00);
        wait_ack(lat);
        rst = 1'b1;
        step();
        chk("rst_ack", uo_out, 8'h00);
        chk("rst_ack_oe", uio_oe, 8'h00);
        rst = 1'b0;
        ui_in = 8'h00;
        reset_model();
        step(3);
        for (int i = 0; i < 17; i++) txn(1'b0, 4'(i % 8), 8'(8'h20 + i));
        chk("wrap_count", {4'h0, uo_out[7:4]}, 8'h01);
        txn(1'b1, 4'd0, 8'h00);
        txn(1'b1, 4'd6, 8'h00);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
